cla64_seq_addsub: RTL and testbench

//  Sequencing stage directly upstream of the 64-bit carry-lookahead adder (CLA64bit).

---
 rtl/cla_pkg.sv | 17 +
 rtl/cla64_seq_addsub.sv | 129 ++++++++++++
 tb/tb_cla64_seq_addsub.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/cla_pkg.sv
// Shared constants for the CLA64 add/sub sequencer: adder width, op encodings
// and FSM state encodings.
package cla_pkg;

    localparam int unsigned ADD_W = 64;

    localparam logic [1:0] OP_ADD64  = 2'b00;
    localparam logic [1:0] OP_SUB64  = 2'b01;
    localparam logic [1:0] OP_ADD128 = 2'b10;
    localparam logic [1:0] OP_SUB128 = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LO   = 2'd1;
    localparam logic [1:0] ST_HI   = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

endpackage

// File: rtl/cla64_seq_addsub.sv
// Sequencer in front of an external 64-bit CLA: runs 64-bit ops in one adder
// pass and 128-bit ops in two chained passes, then holds the result for handoff.
module cla64_seq_addsub #(
    parameter int unsigned ADD_W = cla_pkg::ADD_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_op,
    input  logic [2*ADD_W-1:0]   in_a,
    input  logic [2*ADD_W-1:0]   in_b,
    output logic [ADD_W-1:0]     adder_x,
    output logic [ADD_W-1:0]     adder_y,
    output logic                 adder_cin,
    input  logic [ADD_W-1:0]     adder_s,
    input  logic                 adder_cout,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*ADD_W-1:0]   out_res,
    output logic                 out_carry,
    output logic                 out_ovf
);
    import cla_pkg::*;

    logic [1:0]         state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [2*ADD_W-1:0] a_q, a_d;
    logic [2*ADD_W-1:0] b_q, b_d;
    logic [2*ADD_W-1:0] res_q, res_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;
    logic               is_sub;
    logic               is_128;
    logic               pass_ovf;

    assign is_sub = op_q[0];
    assign is_128 = op_q[1];

    always_comb begin
        adder_x   = '0;
        adder_y   = '0;
        adder_cin = 1'b0;
        case (state_q)
            ST_LO: begin
                adder_x   = a_q[ADD_W-1:0];
                adder_y   = b_q[ADD_W-1:0] ^ {ADD_W{is_sub}};
                adder_cin = is_sub;
            end
            ST_HI: begin
                adder_x   = a_q[2*ADD_W-1:ADD_W];
                adder_y   = b_q[2*ADD_W-1:ADD_W] ^ {ADD_W{is_sub}};
                adder_cin = carry_q;
            end
            default: ;
        endcase
    end

    // Uses the already-inverted y so SUB overflow falls out of the add rule.
    assign pass_ovf = (adder_x[ADD_W-1] == adder_y[ADD_W-1]) &&
                      (adder_s[ADD_W-1] != adder_x[ADD_W-1]);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d    = in_op;
                    a_d     = in_a;
                    b_d     = in_b;
                    res_d   = '0;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                res_d[ADD_W-1:0] = adder_s;
                carry_d          = adder_cout;
                ovf_d            = pass_ovf;
                state_d          = is_128 ? ST_HI : ST_RESP;
            end
            ST_HI: begin
                res_d[2*ADD_W-1:ADD_W] = adder_s;
                carry_d                = adder_cout;
                ovf_d                  = pass_ovf;
                state_d                = ST_RESP;
            end
            default: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_RESP);
    assign out_res   = res_q;
    assign out_carry = carry_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_cla64_seq_addsub.sv
// Directed bench for cla64_seq_addsub with a behavioural 64-bit adder standing
// in for the CLA on the adder_* ports.
module tb_cla64_seq_addsub;

    localparam int unsigned W = 64;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [1:0]     in_op;
    logic [2*W-1:0] in_a;
    logic [2*W-1:0] in_b;
    logic [W-1:0]   adder_x;
    logic [W-1:0]   adder_y;
    logic           adder_cin;
    logic [W-1:0]   adder_s;
    logic           adder_cout;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out_res;
    logic           out_carry;
    logic           out_ovf;

    int n_vec;
    int n_err;

    cla64_seq_addsub #(.ADD_W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .adder_x    (adder_x),
        .adder_y    (adder_y),
        .adder_cin  (adder_cin),
        .adder_s    (adder_s),
        .adder_cout (adder_cout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_res    (out_res),
        .out_carry  (out_carry),
        .out_ovf    (out_ovf)
    );

    assign {adder_cout, adder_s} = {1'b0, adder_x} + {1'b0, adder_y} + {{W{1'b0}}, adder_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one op, check latency, optionally stall out_ready, check result, hand off.
    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [2*W-1:0] a, input logic [2*W-1:0] b,
                          input int stall, input int exp_lat,
                          input logic [2*W-1:0] exp_res, input logic exp_c, input logic exp_v,
                          input bit chk_hi_cin, input logic exp_hi_cin);
        int cyc;
        logic [2*W-1:0] held;
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        check({tag, ".rdy"}, {127'd0, in_ready}, 128'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check({tag, ".busy"}, {127'd0, in_ready}, 128'd0);
            if (cyc == 2 && chk_hi_cin) check({tag, ".hicin"}, {127'd0, adder_cin}, {127'd0, exp_hi_cin});
        end while (!out_valid && cyc < 10);
        check({tag, ".lat"}, 128'(cyc), 128'(exp_lat));
        check({tag, ".res"}, out_res, exp_res);
        check({tag, ".cv"}, {126'd0, out_carry, out_ovf}, {126'd0, exp_c, exp_v});
        held = out_res;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, ".hold"}, {out_res[2*W-1:2], out_valid, in_ready}, {held[2*W-1:2], 1'b1, 1'b0});
            check({tag, ".holdlo"}, {126'd0, out_res[1:0]}, {126'd0, held[1:0]});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check({tag, ".done"}, {126'd0, out_valid, in_ready}, {126'd0, 1'b0, 1'b1});
    endtask

    initial begin
        int cyc;
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        #12;
        check("rst.flags", {124'd0, out_valid, in_ready, out_carry, out_ovf}, {124'd0, 4'b0100});
        check("rst.res", out_res, 128'd0);
        check("rst.adder", {63'd0, adder_x, adder_cin}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add64_wrap", 2'b00, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 128'd1,
               0, 2, 128'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op("add64_ovf", 2'b00, 128'h0000_0000_0000_0000_7FFF_FFFF_FFFF_FFFF, 128'd1,
               0, 2, 128'h0000_0000_0000_0000_8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op("sub64_brw", 2'b01, 128'd5, 128'd7,
               0, 2, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("add128_chain", 2'b10, 128'h0000_0000_0000_0001_FFFF_FFFF_FFFF_FFFF, 128'd1,
               0, 3, 128'h0000_0000_0000_0002_0000_0000_0000_0000, 1'b0, 1'b0, 1'b1, 1'b1);
        run_op("sub128_stall", 2'b11, 128'd0, 128'd1,
               5, 3, {128{1'b1}}, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op("add64_upper", 2'b00, 128'h0000_0000_0000_DEAD_0000_0000_0000_0010,
               128'h0000_0000_0000_BEEF_0000_0000_0000_0020,
               0, 2, 128'h30, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("sub64_eq", 2'b01, 128'd9, 128'd9, 1, 2, 128'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op("sub64_ovf", 2'b01, 128'h0000_0000_0000_0000_8000_0000_0000_0000, 128'd1,
               0, 2, 128'h0000_0000_0000_0000_7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);

        // Reset asserted while the high half is on the adder.
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 2'b10;
        in_a     = {64'd7, 64'd7};
        in_b     = {64'd1, 64'd1};
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rstmid.hicin", {127'd0, adder_cin}, 128'd0);
        check("rstmid.hix", {64'd0, adder_x}, 128'd7);
        rst_n = 1'b0;
        #1;
        check("rstmid.flags", {126'd0, out_valid, in_ready}, {126'd0, 2'b01});
        check("rstmid.adder", {64'd0, adder_x}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) cyc++;
        end
        check("rstmid.noresp", 128'(cyc), 128'd0);
        run_op("post_rst_add", 2'b00, 128'd2, 128'd3, 0, 2, 128'd5, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
